// File: rtl/i2c_master_ctrl_if.sv
// Host command/data and pad signals of the I2C master.
// The controller uses the slave modport; the host side uses master.
interface i2c_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [3:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl_out;
  logic       sda_out;
  logic       sda_in;

  modport master (
    output cmd_valid, cmd_addr, cmd_rw, cmd_len,
    output wr_data, wr_valid, sda_in,
    input  cmd_ready, wr_ready, rd_data, rd_valid,
    input  busy, done, nack, scl_out, sda_out
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_rw, cmd_len,
    input  wr_data, wr_valid, sda_in,
    output cmd_ready, wr_ready, rd_data, rd_valid,
    output busy, done, nack, scl_out, sda_out
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: START, address, data, ACK and STOP sequencing
// with a built-in quarter-period SCL generator.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input logic          clk,
  input logic          rst_,
  i2c_master_ctrl_if.slave bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_MACK,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [DW-1:0] r_div;
  logic [1:0]    r_q;
  logic [2:0]    r_bit;
  logic [3:0]    r_left;
  logic          r_rw;
  logic [7:0]    r_sh;
  logic          r_have;
  logic          r_ack;
  logic          r_nack;
  logic          r_done;
  logic          r_rdv;
  logic [7:0]    r_rdd;

  logic w_acc;
  logic w_load;
  logic w_frz;
  logic w_tick;
  logic w_samp;
  logic w_bend;
  logic w_scl;
  logic w_sda;
  logic w_dat;
  logic w_enter;

  assign w_acc  = (r_state == S_IDLE) & bus.cmd_valid & ~rst_;
  assign w_load = (r_state == S_WDATA) & ~r_have & bus.wr_valid;
  assign w_frz  = (r_state == S_WDATA) & ~r_have & ~bus.wr_valid;
  assign w_tick = ~w_frz & (r_state != S_IDLE) & (r_div == DIV_MAX);
  assign w_samp = w_tick & (r_q == 2'd2);
  assign w_bend = w_tick & (r_q == 2'd3);
  assign w_dat  = (r_state == S_ADDR) | (r_state == S_WDATA);
  assign w_enter = w_bend & (r_state != w_nxt) &
                   ((w_nxt == S_WDATA) | (w_nxt == S_RDATA));

  assign bus.cmd_ready = (r_state == S_IDLE) & ~rst_;
  assign bus.wr_ready  = w_load;
  assign bus.rd_data   = r_rdd;
  assign bus.rd_valid  = r_rdv;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.nack      = r_nack;
  assign bus.scl_out   = w_scl;
  assign bus.sda_out   = w_sda;

  // state register
  always_ff @(posedge clk) begin
    if (rst_) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // next state and pad levels per quarter
  always_comb begin
    w_nxt = r_state;
    w_scl = 1'b1;
    w_sda = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) w_nxt = S_START;
      end
      S_START: begin
        w_scl = (r_q != 2'd3);
        w_sda = ~r_q[1];
        if (w_bend) w_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_scl = r_q[1];
        w_sda = r_sh[7];
        if (w_bend && r_bit == 3'd0) w_nxt = S_AACK;
      end
      S_AACK: begin
        w_scl = r_q[1];
        if (w_bend) begin
          if (r_ack || r_left == 4'd0) w_nxt = S_STOP;
          else if (r_rw)               w_nxt = S_RDATA;
          else                         w_nxt = S_WDATA;
        end
      end
      S_WDATA: begin
        w_scl = r_q[1];
        if (r_have)            w_sda = r_sh[7];
        else if (bus.wr_valid) w_sda = bus.wr_data[7];
        if (w_bend && r_bit == 3'd0) w_nxt = S_WACK;
      end
      S_WACK: begin
        w_scl = r_q[1];
        if (w_bend) begin
          if (r_ack || r_left == 4'd0) w_nxt = S_STOP;
          else                         w_nxt = S_WDATA;
        end
      end
      S_RDATA: begin
        w_scl = r_q[1];
        if (w_bend && r_bit == 3'd0) w_nxt = S_MACK;
      end
      S_MACK: begin
        w_scl = r_q[1];
        w_sda = (r_left == 4'd0);
        if (w_bend) begin
          if (r_left == 4'd0) w_nxt = S_STOP;
          else                w_nxt = S_RDATA;
        end
      end
      S_STOP: begin
        w_scl = (r_q != 2'd0);
        w_sda = r_q[1];
        if (w_bend) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // quarter/bit timing, shifter, byte count and status flags
  always_ff @(posedge clk) begin
    if (rst_) begin
      r_div  <= '0;
      r_q    <= 2'd0;
      r_bit  <= 3'd0;
      r_left <= 4'd0;
      r_rw   <= 1'b0;
      r_sh   <= 8'd0;
      r_have <= 1'b0;
      r_ack  <= 1'b0;
      r_nack <= 1'b0;
      r_done <= 1'b0;
      r_rdv  <= 1'b0;
      r_rdd  <= 8'd0;
    end else begin
      r_done <= (r_state == S_STOP) & w_bend;
      r_rdv  <= (r_state == S_RDATA) & w_samp &
                (r_bit == 3'd0);
      if (r_state == S_IDLE) begin
        r_div <= '0;
        r_q   <= 2'd0;
      end else if (!w_frz) begin
        r_div <= w_tick ? '0 : r_div + DW'(1);
        if (w_tick) r_q <= r_q + 2'd1;
      end
      if (w_acc) begin
        r_sh   <= {bus.cmd_addr, bus.cmd_rw};
        r_rw   <= bus.cmd_rw;
        r_left <= bus.cmd_len;
        r_nack <= 1'b0;
        r_bit  <= 3'd7;
      end else begin
        if (w_load)
          r_sh <= bus.wr_data;
        else if (w_bend && w_dat)
          r_sh <= {r_sh[6:0], 1'b0};
        else if (w_samp && r_state == S_RDATA)
          r_sh <= {r_sh[6:0], bus.sda_in};
        if (w_bend && (w_dat || r_state == S_RDATA))
          r_bit <= r_bit - 3'd1;
        if (w_enter) r_left <= r_left - 4'd1;
      end
      if (w_samp) r_ack <= bus.sda_in;
      if (w_samp && bus.sda_in &&
          (r_state == S_AACK || r_state == S_WACK))
        r_nack <= 1'b1;
      if (w_samp && r_state == S_RDATA && r_bit == 3'd0)
        r_rdd <= {r_sh[6:0], bus.sda_in};
      if (w_load)                 r_have <= 1'b1;
      else if (r_state != S_WDATA) r_have <= 1'b0;
    end
  end

endmodule
